// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply (MUL_STEP bits per cycle), restoring radix-2 divide.
module ex_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_ex,
    input  logic [2:0]      muldiv_code_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic [4:0]      rd_adr_ex,
    input  logic            stall,
    input  logic            kill,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result_ex,
    output logic [4:0]      rd_adr_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W      = $clog2(XLEN + 1);
    localparam int MUL_CYCLES = XLEN / MUL_STEP;

    logic [1:0]        state;
    logic [2:0]        code_q;
    logic [CNT_W-1:0]  cnt;
    logic              res_neg;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    logic              signed_a;
    logic              signed_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [2*XLEN-1:0] mul_partial;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_final;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   q_final;
    logic [XLEN-1:0]   r_final;

    assign stall_req    = start_ex & (state != S_DONE);
    assign busy         = (state == S_MUL) | (state == S_DIV);
    assign result_valid = (state == S_DONE);

    // Operands are reduced to magnitudes up front; MUL itself is treated as
    // unsigned since only its low half is returned.
    always_comb begin
        signed_a = (muldiv_code_ex == 3'b001) | (muldiv_code_ex == 3'b010) |
                   (muldiv_code_ex == 3'b100) | (muldiv_code_ex == 3'b110);
        signed_b = (muldiv_code_ex == 3'b001) | (muldiv_code_ex == 3'b100) |
                   (muldiv_code_ex == 3'b110);
        a_neg    = signed_a & rs1_data_ex[XLEN-1];
        b_neg    = signed_b & rs2_data_ex[XLEN-1];
        abs_a    = a_neg ? -rs1_data_ex : rs1_data_ex;
        abs_b    = b_neg ? -rs2_data_ex : rs2_data_ex;
    end

    always_comb begin
        mul_partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                mul_partial = mul_partial + (mcand << j);
            end
        end
        acc_next   = acc + mul_partial;
        prod_final = res_neg ? -acc_next : acc_next;
    end

    // One restoring step: shift in the next dividend bit, keep the difference
    // only when it did not go negative.
    always_comb begin
        rem_shift = {rem, quo[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, divisor};
        if (!rem_diff[XLEN]) begin
            rem_next = rem_diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
        q_final = res_neg ? -quo_next : quo_next;
        r_final = res_neg ? -rem_next : rem_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            code_q     <= '0;
            cnt        <= '0;
            res_neg    <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            divisor    <= '0;
            quo        <= '0;
            rem        <= '0;
            result_ex  <= '0;
            rd_adr_out <= '0;
        end else if (kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ex) begin
                        code_q     <= muldiv_code_ex;
                        rd_adr_out <= rd_adr_ex;
                        if (!muldiv_code_ex[2]) begin
                            state   <= S_MUL;
                            mcand   <= {{XLEN{1'b0}}, abs_a};
                            mplier  <= abs_b;
                            acc     <= '0;
                            cnt     <= CNT_W'(MUL_CYCLES);
                            res_neg <= a_neg ^ b_neg;
                        end else if (rs2_data_ex == '0) begin
                            // Divide by zero: no iteration needed.
                            state     <= S_DONE;
                            result_ex <= muldiv_code_ex[1] ? rs1_data_ex : '1;
                        end else begin
                            state   <= S_DIV;
                            divisor <= abs_b;
                            quo     <= abs_a;
                            rem     <= '0;
                            cnt     <= CNT_W'(XLEN);
                            res_neg <= muldiv_code_ex[1] ? a_neg : (a_neg ^ b_neg);
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= S_DONE;
                        result_ex <= (code_q == 3'b000) ? prod_final[XLEN-1:0]
                                                        : prod_final[2*XLEN-1:XLEN];
                    end
                end
                S_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - 1'b1;
                    // Signed overflow falls out naturally: |q| = 2^(XLEN-1), sign positive.
                    if (cnt == CNT_W'(1)) begin
                        state     <= S_DONE;
                        result_ex <= code_q[1] ? r_final : q_final;
                    end
                end
                S_DONE: begin
                    if (!stall) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases plus random ops
// checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

    localparam int XLEN     = 32;
    localparam int MUL_STEP = 4;
    localparam int MUL_LAT  = XLEN / MUL_STEP + 1;
    localparam int DIV_LAT  = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_ex;
    logic [2:0]      muldiv_code_ex;
    logic [XLEN-1:0] rs1_data_ex;
    logic [XLEN-1:0] rs2_data_ex;
    logic [4:0]      rd_adr_ex;
    logic            stall;
    logic            kill;
    logic            stall_req;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result_ex;
    logic [4:0]      rd_adr_out;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_ex       (start_ex),
        .muldiv_code_ex (muldiv_code_ex),
        .rs1_data_ex    (rs1_data_ex),
        .rs2_data_ex    (rs2_data_ex),
        .rd_adr_ex      (rd_adr_ex),
        .stall          (stall),
        .kill           (kill),
        .stall_req      (stall_req),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_ex      (result_ex),
        .rd_adr_out     (rd_adr_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] refResult(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        case (code)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] code, input logic [31:0] b);
        if (!code[2]) return MUL_LAT;
        return (b == 0) ? 1 : DIV_LAT;
    endfunction

    // Starts an op in the current (IDLE) cycle, scrambles inputs while busy,
    // holds DONE for stallCycles, and leaves the unit in IDLE.
    task automatic applyStimulus(input string tag, input logic [2:0] code, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input int stallCycles);
        int cyc;
        int badReq;
        int badBusy;
        logic [31:0] expRes;
        expRes = refResult(code, a, b);
        start_ex       = 1'b1;
        muldiv_code_ex = code;
        rs1_data_ex    = a;
        rs2_data_ex    = b;
        rd_adr_ex      = rd;
        stall          = 1'b0;
        #1;
        checkOutput({tag, "_req0"}, {31'b0, stall_req}, 32'd1);
        cyc = 0;
        badReq = 0;
        badBusy = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (result_valid) break;
            if (!stall_req) badReq++;
            if (!busy) badBusy++;
            rs1_data_ex    = $urandom;
            rs2_data_ex    = $urandom;
            muldiv_code_ex = 3'($urandom);
            rd_adr_ex      = 5'($urandom);
        end
        checkOutput({tag, "_lat"}, cyc, refLatency(code, b));
        checkOutput({tag, "_res"}, result_ex, expRes);
        checkOutput({tag, "_rd"}, {27'b0, rd_adr_out}, {27'b0, rd});
        checkOutput({tag, "_reqhold"}, badReq, 0);
        checkOutput({tag, "_busy"}, badBusy, 0);
        checkOutput({tag, "_reqdone"}, {31'b0, stall_req}, 32'd0);
        start_ex = 1'b0;
        for (int s = 0; s < stallCycles; s++) begin
            stall = 1'b1;
            @(posedge clk);
            #1;
            checkOutput({tag, "_stlv"}, {31'b0, result_valid}, 32'd1);
            checkOutput({tag, "_stlr"}, result_ex, expRes);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle"}, {30'b0, busy, result_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [2:0]  rc;
        logic [31:0] ra, rb;
        rst = 1'b1;
        start_ex = 1'b0;
        muldiv_code_ex = '0;
        rs1_data_ex = '0;
        rs2_data_ex = '0;
        rd_adr_ex = '0;
        stall = 1'b0;
        kill = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_state", {25'b0, busy, result_valid, rd_adr_out}, 32'd0);
        checkOutput("rst_res", result_ex, 32'd0);

        applyStimulus("mul7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
        applyStimulus("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 0);
        applyStimulus("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
        applyStimulus("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd6, 0);
        applyStimulus("div-7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
        applyStimulus("rem-7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
        applyStimulus("divu", 3'b101, 32'd100, 32'd7, 5'd9, 0);
        applyStimulus("remu", 3'b111, 32'd100, 32'd7, 5'd10, 0);
        applyStimulus("div5/0", 3'b100, 32'd5, 32'd0, 5'd11, 0);
        applyStimulus("rem5/0", 3'b110, 32'd5, 32'd0, 5'd12, 0);
        applyStimulus("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
        applyStimulus("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
        applyStimulus("mul6x7stl", 3'b000, 32'd6, 32'd7, 5'd15, 3);

        // Kill mid-divide, then a fresh multiply.
        start_ex = 1'b1;
        muldiv_code_ex = 3'b100;
        rs1_data_ex = 32'd1000;
        rs2_data_ex = 32'd3;
        rd_adr_ex = 5'd16;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        start_ex = 1'b0;
        checkOutput("kill_out", {30'b0, busy, result_valid}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus("mul3x4", 3'b000, 32'd3, 32'd4, 5'd17, 0);

        // kill together with start: nothing starts.
        start_ex = 1'b1;
        kill = 1'b1;
        muldiv_code_ex = 3'b000;
        @(posedge clk);
        #1;
        kill = 1'b0;
        start_ex = 1'b0;
        checkOutput("killstart", {30'b0, busy, result_valid}, 32'd0);

        // Reset in cycle 5 of an op.
        start_ex = 1'b1;
        muldiv_code_ex = 3'b101;
        rs1_data_ex = 32'd77;
        rs2_data_ex = 32'd5;
        rd_adr_ex = 5'd21;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        start_ex = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_mid", {24'b0, stall_req, busy, result_valid, rd_adr_out}, 32'd0);
        checkOutput("rst_midres", result_ex, 32'd0);

        for (int n = 0; n < 40; n++) begin
            rc = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            applyStimulus("rand", rc, ra, rb, 5'($urandom), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
